// File: rtl/pe_pkg.sv
// Shared types and constants for the priority-encoder index stage.
package pe_pkg;

  localparam int PE_WIDTH = 64;
  localparam int PE_IDX_W = 6;

  // One FIFO entry: encoded index plus the two vector-shape flags.
  typedef struct packed {
    logic [PE_IDX_W-1:0] idx;
    logic                none;
    logic                multi;
  } pe_idx_entry_t;

endpackage : pe_pkg

// File: rtl/onehot_enc64.sv
// Combinational one-hot to binary encoder (bitwise-OR tree).
// Optional feature macro: ONEHOT_CHECK_EN -- flags multi-hot vectors and
// substitutes the index of the highest set bit for them.
module onehot_enc64
  import pe_pkg::*;
#(
  parameter int WIDTH = PE_WIDTH,
  parameter int IDX_W = PE_IDX_W
) (
  input  logic [WIDTH-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             none,
  output logic             multi
);

  logic [IDX_W-1:0] or_idx;

  // OR-tree: index bit k is the OR of every input bit whose position has bit k set.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' and assigns a default first,
    // so every path drives the signal and no latch is inferred.
    or_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      or_idx = or_idx | ({IDX_W{onehot[i]}} & IDX_W'(i));
    end
  end

  assign none = ~|onehot;

`ifdef ONEHOT_CHECK_EN
  logic [IDX_W-1:0] hi_idx;

  // Highest set bit wins, matching the upstream priority order.
  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot[i]) hi_idx = IDX_W'(i);
    end
  end

  // More than one bit set exactly when clearing the lowest set bit leaves something.
  assign multi = |(onehot & (onehot - WIDTH'(1)));
  assign idx   = multi ? hi_idx : or_idx;
`else
  assign multi = 1'b0;
  assign idx   = or_idx;
`endif

endmodule : onehot_enc64

// File: rtl/pe_index_encoder.sv
// One-hot grant vector to binary index converter with a small output FIFO,
// valid/ready handshakes on both sides and a running grant counter.
// Optional feature macro: ONEHOT_CHECK_EN (multi-hot detection, see onehot_enc64).
module pe_index_encoder
  import pe_pkg::*;
#(
  parameter int WIDTH = PE_WIDTH,
  parameter int IDX_W = PE_IDX_W,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_onehot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_none,
  output logic             out_multi,
  output logic [CNT_W-1:0] grant_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  pe_idx_entry_t    mem [DEPTH];
  pe_idx_entry_t    wr_entry;
  pe_idx_entry_t    head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] count;
  logic             push;
  logic             pop;

  onehot_enc64 #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_enc (
    .onehot (in_onehot),
    .idx    (wr_entry.idx),
    .none   (wr_entry.none),
    .multi  (wr_entry.multi)
  );

  // Registered occupancy drives in_ready: a full FIFO never accepts, even when
  // the consumer pops in the same cycle.
  assign in_ready  = (count < FULL_OCC);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head outputs are masked while empty so reset and idle values read as zero.
  assign head      = mem[rd_ptr];
  assign out_idx   = out_valid ? head.idx   : '0;
  assign out_none  = out_valid ? head.none  : 1'b0;
  assign out_multi = out_valid ? head.multi : 1'b0;

  // FIFO storage write at the tail.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; count gates every read, so stale
    // contents are never visible and the array can map to plain registers/RAM.
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking '<=' so all registers update
    // together from pre-edge values.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Count accepted non-zero vectors, wrapping at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else if (push && !wr_entry.none) begin
      grant_cnt <= grant_cnt + CNT_W'(1);
    end
  end

endmodule : pe_index_encoder

// File: tb/tb_pe_index_encoder.sv
// Directed self-checking bench for pe_index_encoder. Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
module tb_pe_index_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_onehot;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_idx;
  logic        out_none;
  logic        out_multi;
  logic [15:0] grant_cnt;

  int checks   = 0;
  int failures = 0;

  pe_index_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_onehot (in_onehot),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_none  (out_none),
    .out_multi (out_multi),
    .grant_cnt (grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_onehot = '0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_idx",   64'(out_idx),   64'd0);
    check("rst_out_none",  64'(out_none),  64'd0);
    check("rst_out_multi", 64'(out_multi), 64'd0);
    check("rst_grant_cnt", 64'(grant_cnt), 64'd0);
    rst_n = 1'b1;
    step();

    // Single push, latency one cycle.
    in_valid  = 1'b1;
    in_onehot = 64'h0000_0000_0001_0000;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("p16_valid", 64'(out_valid), 64'd1);
    check("p16_idx",   64'(out_idx),   64'd16);
    check("p16_none",  64'(out_none),  64'd0);
    check("p16_cnt",   64'(grant_cnt), 64'd1);
    step();
    check("p16_drain", 64'(out_valid), 64'd0);

    // Two back-to-back pushes with stalled consumer fill the FIFO.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_onehot = 64'h8000_0000_0000_0000;
    step();
    check("b2b_ready1", 64'(in_ready), 64'd1);
    in_onehot = 64'h1;
    step();
    in_valid = 1'b0;
    check("b2b_full",  64'(in_ready), 64'd0);
    check("b2b_head",  64'(out_idx),  64'd63);
    step();
    check("b2b_stable", 64'(out_idx), 64'd63);
    out_ready = 1'b1;
    step();
    check("b2b_second_valid", 64'(out_valid), 64'd1);
    check("b2b_second_idx",   64'(out_idx),   64'd0);
    step();
    check("b2b_empty", 64'(out_valid), 64'd0);
    check("b2b_cnt",   64'(grant_cnt), 64'd3);

    // All-zero vector.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_onehot = 64'h0;
    step();
    in_valid = 1'b0;
    check("zero_valid", 64'(out_valid), 64'd1);
    check("zero_none",  64'(out_none),  64'd1);
    check("zero_idx",   64'(out_idx),   64'd0);
    check("zero_cnt",   64'(grant_cnt), 64'd3);
    out_ready = 1'b1;
    step();

    // Multi-hot vector.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_onehot = 64'h24;
    step();
    in_valid = 1'b0;
`ifdef ONEHOT_CHECK_EN
    check("multi_flag", 64'(out_multi), 64'd1);
    check("multi_idx",  64'(out_idx),   64'd5);
`else
    check("multi_flag", 64'(out_multi), 64'd0);
    check("multi_idx",  64'(out_idx),   64'd7);
`endif
    check("multi_none", 64'(out_none),  64'd0);
    check("multi_cnt",  64'(grant_cnt), 64'd4);
    out_ready = 1'b1;
    step();
    check("multi_drain", 64'(out_valid), 64'd0);

    // Full FIFO: simultaneous in_valid and out_ready pops without pushing.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_onehot = 64'h2;
    step();
    in_onehot = 64'h4;
    step();
    check("full_ready", 64'(in_ready), 64'd0);
    in_onehot = 64'h8;
    out_ready = 1'b1;
    step();
    check("full_pop_idx",   64'(out_idx),   64'd2);
    check("full_nopush",    64'(grant_cnt), 64'd6);
    check("full_ready_up",  64'(in_ready),  64'd1);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("full_push_cnt",  64'(grant_cnt), 64'd7);
    check("full_head_hold", 64'(out_idx),   64'd2);
    check("full_again",     64'(in_ready),  64'd0);

    // Asynchronous reset with two entries queued.
    rst_n = 1'b0;
    #2;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_cnt",   64'(grant_cnt), 64'd0);
    check("arst_ready", 64'(in_ready),  64'd1);
    #1;
    rst_n = 1'b1;
    step();
    check("arst_stay_empty", 64'(out_valid), 64'd0);

    // Counter wrap: 65535 grants, then one more.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_onehot = 64'h1;
    repeat (65535) step();
    check("wrap_max",   64'(grant_cnt), 64'hFFFF);
    step();
    in_valid = 1'b0;
    check("wrap_zero",  64'(grant_cnt), 64'd0);
    check("wrap_valid", 64'(out_valid), 64'd1);
    step();
    check("wrap_drain", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pe_index_encoder
